// File: rtl/serial_tx_port.sv
// Memory-mapped 8N1 UART transmitter.
// Bytes written by the core are queued in a small FIFO and shifted out LSB first on txd.
module serial_tx_port #(
  parameter logic [31:0] BASE       = 32'h0000_0200,
  parameter int          DEPTH_LOG2 = 3,
  parameter logic [15:0] DIV_RESET  = 16'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        rw,
  input  logic [31:0] addr,
  inout  wire  [31:0] data,
  output logic        txd,
  output logic        busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  txd_q, txd_d;
  logic                  busy_q, busy_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [7:0]            shift_q, shift_d;
  logic [15:0]           divisor_q, divisor_d;
  logic                  ovf_q, ovf_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]            mem_q [DEPTH];
  logic [7:0]            mem_d [DEPTH];

  logic [31:0] addr_off;
  logic        sel;
  logic        wr_txdata;
  logic        wr_status;
  logic        wr_div;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push;
  logic [15:0] period_m1;
  logic [3:0]  count4;
  logic [31:0] rdata;
  logic        unused_data_hi;

  // Offset compare also rejects addresses below BASE, since they wrap to huge offsets.
  assign addr_off  = addr - BASE;
  assign sel       = enable && (addr_off < 32'd3);
  assign wr_txdata = sel && rw && (addr_off[1:0] == 2'd0);
  assign wr_status = sel && rw && (addr_off[1:0] == 2'd1);
  assign wr_div    = sel && rw && (addr_off[1:0] == 2'd2);

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_CNT);
  assign pop       = (state_q == IDLE) && !empty;
  assign push      = wr_txdata && (!full || pop);
  assign period_m1 = (divisor_q == 16'd0) ? 16'd0 : (divisor_q - 16'd1);
  assign count4    = 4'(count_q);
  assign unused_data_hi = ^data[31:16];

  always_comb begin
    rdata = 32'd0;
    case (addr_off[1:0])
      2'd1:    rdata = {20'd0, count4, 4'd0, ovf_q, busy_q, empty, full};
      2'd2:    rdata = {16'd0, divisor_q};
      default: rdata = 32'd0;
    endcase
  end

  assign data = (sel && !rw) ? rdata : 32'bz;

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    divisor_d = divisor_q;
    if (push) begin
      mem_d[wr_ptr_q] = data[7:0];
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    // A rejected byte on the same edge as a clear leaves the flag set.
    if (wr_status && data[3]) begin
      ovf_d = 1'b0;
    end
    if (wr_txdata && !push) begin
      ovf_d = 1'b1;
    end
    if (wr_div) begin
      divisor_d = data[15:0];
    end
  end

  // Bit timer reloads only at a bit boundary, so divisor writes never cut a bit short.
  always_comb begin
    state_d   = state_q;
    txd_d     = txd_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          cnt_d   = period_m1;
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == 16'd0) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          txd_d     = shift_q[0];
          cnt_d     = period_m1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = period_m1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        txd_d = 1'b1;
        if (cnt_q == 16'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
    endcase
    busy_d = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      cnt_q     <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      divisor_q <= DIV_RESET;
      ovf_q     <= 1'b0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      divisor_q <= divisor_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign txd  = txd_q;
  assign busy = busy_q;

endmodule
